uart_buffered: RTL and testbench



---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_sync_fifo.sv | 48 ++++
 rtl/uart_buffered.sv | 276 +++++++++++++++++++++++++++
 tb/tb_uart_buffered.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and state types for the buffered UART.
//   - register addresses (DATA, STATUS, DIV_LO, DIV_HI)
//   - STATUS bit positions
//   - TX / RX state enums (PARITY states exist only with UART_PARITY_EN)
package uart_pkg;

  localparam logic [1:0] UART_REG_DATA   = 2'd0;
  localparam logic [1:0] UART_REG_STATUS = 2'd1;
  localparam logic [1:0] UART_REG_DIV_LO = 2'd2;
  localparam logic [1:0] UART_REG_DIV_HI = 2'd3;

  localparam int ST_TX_FULL = 7;
  localparam int ST_RX_NE   = 6;
  localparam int ST_OVR     = 5;
  localparam int ST_FRM     = 4;
  localparam int ST_PAR     = 3;
  localparam int ST_BUSY    = 0;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_WAIT    // stop bit was low: hold off until the line returns high
  } rx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: power-of-two synchronous FIFO with first-word fall-through head.
// Ports:
//   i_clk, i_rst_n  clock, async active-low reset (pointers only)
//   i_push, i_din   write request / data (ignored when full unless popping)
//   i_pop           read request (ignored when empty)
//   o_full, o_empty status
//   o_head          current head entry (valid when !o_empty)
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wp, r_rp;   // extra MSB is the wrap bit
  logic             w_wr, w_rd;

  assign o_empty = (r_wp == r_rp);
  assign o_full  = (r_wp[AW-1:0] == r_rp[AW-1:0]) && (r_wp[AW] != r_rp[AW]);
  assign w_rd    = i_pop && !o_empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign w_wr    = i_push && (!o_full || w_rd);
  assign o_head  = r_mem[r_rp[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wp[AW-1:0]] <= i_din;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + ONE;
      if (w_rd) r_rp <= r_rp + ONE;
    end
  end
endmodule

// File: rtl/uart_buffered.sv
// uart_buffered: 4-register bus UART with TX/RX FIFOs, 16-bit runtime divisor
// and sticky error flags. 8N1; define UART_PARITY_EN for 8E1.
// Ports:
//   clk, rst   clock, async active-low reset
//   addr       register select (DATA, STATUS, DIV_LO, DIV_HI)
//   dbw, we    write data / one-cycle write strobe
//   re         one-cycle read strobe (pops RX at DATA, clears flags at STATUS)
//   dbr        combinational read data
//   rx, tx     serial in (async) / registered serial out, idle high
module uart_buffered
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 1612800,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] addr,
  input  logic [7:0] dbw,
  input  logic       we,
  input  logic       re,
  output logic [7:0] dbr,
  input  logic       rx,
  output logic       tx
);
  localparam logic [15:0] DIV_RST = 16'(CLK_HZ / BAUD - 1);

  logic [15:0] r_div;
  logic        w_txf_push, w_txf_pop, w_txf_full, w_txf_empty;
  logic        w_rxf_push, w_rxf_pop, w_rxf_full, w_rxf_empty;
  logic [7:0]  w_txf_head, w_rxf_head;

  // ---------------- bus registers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_div <= DIV_RST;
    else if (we) begin
      if (addr == UART_REG_DIV_LO) r_div[7:0]  <= dbw;
      if (addr == UART_REG_DIV_HI) r_div[15:8] <= dbw;
    end
  end

  assign w_txf_push = we && (addr == UART_REG_DATA);
  assign w_rxf_pop  = re && (addr == UART_REG_DATA);

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_clk(clk), .i_rst_n(rst), .i_push(w_txf_push), .i_din(dbw), .i_pop(w_txf_pop),
    .o_full(w_txf_full), .o_empty(w_txf_empty), .o_head(w_txf_head));

  // ---------------- transmitter ----------------
  tx_state_e   r_tx_st, w_tx_nxt;
  logic [15:0] r_tx_cnt, r_tx_div;
  logic [7:0]  r_tx_sh;
  logic [2:0]  r_tx_bit;
  logic        r_tx, w_tx_line, w_tx_done;
`ifdef UART_PARITY_EN
  logic        r_tx_par;
`endif

  assign w_tx_done = (r_tx_cnt == r_tx_div);

  always_comb begin
    w_tx_nxt  = r_tx_st;
    w_txf_pop = 1'b0;
    w_tx_line = 1'b1;
    case (r_tx_st)
      TX_IDLE: if (!w_txf_empty) begin
        w_tx_nxt  = TX_START;
        w_txf_pop = 1'b1;
      end
      TX_START: begin
        w_tx_line = 1'b0;
        if (w_tx_done) w_tx_nxt = TX_DATA;
      end
      TX_DATA: begin
        w_tx_line = r_tx_sh[0];
`ifdef UART_PARITY_EN
        if (w_tx_done && r_tx_bit == 3'd7) w_tx_nxt = TX_PARITY;
      end
      TX_PARITY: begin
        w_tx_line = r_tx_par;
        if (w_tx_done) w_tx_nxt = TX_STOP;
`else
        if (w_tx_done && r_tx_bit == 3'd7) w_tx_nxt = TX_STOP;
`endif
      end
      TX_STOP: if (w_tx_done) begin
        // chain straight into the next start bit when more data is queued
        if (!w_txf_empty) begin
          w_tx_nxt  = TX_START;
          w_txf_pop = 1'b1;
        end else begin
          w_tx_nxt  = TX_IDLE;
        end
      end
      default: w_tx_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_tx_st <= TX_IDLE;
    else      r_tx_st <= w_tx_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_cnt <= '0;
      r_tx_div <= '0;
      r_tx_sh  <= '0;
      r_tx_bit <= '0;
      r_tx     <= 1'b1;
`ifdef UART_PARITY_EN
      r_tx_par <= 1'b0;
`endif
    end else begin
      r_tx <= w_tx_line;
      if (w_txf_pop) begin
        // frame start: byte and divisor are frozen for the whole frame
        r_tx_sh  <= w_txf_head;
        r_tx_div <= r_div;
        r_tx_cnt <= '0;
        r_tx_bit <= '0;
`ifdef UART_PARITY_EN
        r_tx_par <= ^w_txf_head;
`endif
      end else if (r_tx_st != TX_IDLE) begin
        if (w_tx_done) begin
          r_tx_cnt <= '0;
          if (r_tx_st == TX_DATA) begin
            r_tx_sh  <= r_tx_sh >> 1;
            r_tx_bit <= r_tx_bit + 3'd1;
          end
        end else begin
          r_tx_cnt <= r_tx_cnt + 16'd1;
        end
      end
    end
  end

  assign tx = r_tx;

  // ---------------- receiver ----------------
  rx_state_e   r_rx_st, w_rx_nxt;
  logic        r_rx_s1, r_rx_s2;
  logic [15:0] r_rx_cnt, r_rx_div;
  logic [7:0]  r_rx_sh;
  logic [2:0]  r_rx_bit;
  logic        w_rx_half, w_rx_done, w_frm_set, w_ovr_set;
`ifdef UART_PARITY_EN
  logic        w_par_set;
`endif

  assign w_rx_half = (r_rx_cnt == (r_rx_div >> 1));
  assign w_rx_done = (r_rx_cnt == r_rx_div);

  always_comb begin
    w_rx_nxt   = r_rx_st;
    w_rxf_push = 1'b0;
    w_frm_set  = 1'b0;
`ifdef UART_PARITY_EN
    w_par_set  = 1'b0;
`endif
    case (r_rx_st)
      RX_IDLE:  if (!r_rx_s2) w_rx_nxt = RX_START;
      // mid start bit: a high line here means the edge was a glitch
      RX_START: if (w_rx_half) w_rx_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
`ifdef UART_PARITY_EN
      RX_DATA:  if (w_rx_done && r_rx_bit == 3'd7) w_rx_nxt = RX_PARITY;
      RX_PARITY: if (w_rx_done) begin
        w_rx_nxt  = RX_STOP;
        w_par_set = (r_rx_s2 != ^r_rx_sh);
      end
`else
      RX_DATA:  if (w_rx_done && r_rx_bit == 3'd7) w_rx_nxt = RX_STOP;
`endif
      RX_STOP: if (w_rx_done) begin
        w_rxf_push = 1'b1;
        if (r_rx_s2) w_rx_nxt = RX_IDLE;
        else begin
          w_frm_set = 1'b1;
          w_rx_nxt  = RX_WAIT;
        end
      end
      RX_WAIT: if (r_rx_s2) w_rx_nxt = RX_IDLE;
      default: w_rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rx_st <= RX_IDLE;
    else      r_rx_st <= w_rx_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_s1  <= 1'b1;
      r_rx_s2  <= 1'b1;
      r_rx_cnt <= '0;
      r_rx_div <= '0;
      r_rx_sh  <= '0;
      r_rx_bit <= '0;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      if (r_rx_st == RX_IDLE) begin
        // divisor tracks the register until a frame begins
        r_rx_cnt <= '0;
        r_rx_div <= r_div;
        r_rx_bit <= '0;
      end else if ((r_rx_st == RX_START && w_rx_half) || w_rx_done) begin
        r_rx_cnt <= '0;
      end else begin
        r_rx_cnt <= r_rx_cnt + 16'd1;
      end
      if (r_rx_st == RX_DATA && w_rx_done) begin
        r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
        r_rx_bit <= r_rx_bit + 3'd1;
      end
    end
  end

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk(clk), .i_rst_n(rst), .i_push(w_rxf_push), .i_din(r_rx_sh), .i_pop(w_rxf_pop),
    .o_full(w_rxf_full), .o_empty(w_rxf_empty), .o_head(w_rxf_head));

  // ---------------- sticky flags ----------------
  logic w_st_rd, r_ovr, r_frm;
`ifdef UART_PARITY_EN
  logic r_par;
`endif

  assign w_st_rd   = re && (addr == UART_REG_STATUS);
  assign w_ovr_set = w_rxf_push && w_rxf_full && !w_rxf_pop;

  // set wins over a same-cycle clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovr <= 1'b0;
      r_frm <= 1'b0;
`ifdef UART_PARITY_EN
      r_par <= 1'b0;
`endif
    end else begin
      r_ovr <= (r_ovr && !w_st_rd) || w_ovr_set;
      r_frm <= (r_frm && !w_st_rd) || w_frm_set;
`ifdef UART_PARITY_EN
      r_par <= (r_par && !w_st_rd) || w_par_set;
`endif
    end
  end

  // ---------------- read mux ----------------
  logic [7:0] w_status;
  always_comb begin
    w_status             = 8'h00;
    w_status[ST_TX_FULL] = w_txf_full;
    w_status[ST_RX_NE]   = !w_rxf_empty;
    w_status[ST_OVR]     = r_ovr;
    w_status[ST_FRM]     = r_frm;
`ifdef UART_PARITY_EN
    w_status[ST_PAR]     = r_par;
`endif
    w_status[ST_BUSY]    = (r_tx_st != TX_IDLE);
  end

  always_comb begin
    dbr = 8'h00;
    case (addr)
      UART_REG_DATA:   dbr = w_rxf_empty ? 8'h00 : w_rxf_head;
      UART_REG_STATUS: dbr = w_status;
      UART_REG_DIV_LO: dbr = r_div[7:0];
      UART_REG_DIV_HI: dbr = r_div[15:8];
      default:         dbr = 8'h00;
    endcase
  end
endmodule

// File: tb/tb_uart_buffered.sv
// tb_uart_buffered: scoreboard bench for uart_buffered. Register reads and TX
// frames push expected values into queues; a read monitor and a serial TX
// decoder pop and compare. Honours UART_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_buffered;
  import uart_pkg::*;

  localparam int P = 14;  // clocks per bit at the reset divisor (13+1)
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0, rst = 1'b1;
  logic [1:0] addr = 2'd0;
  logic [7:0] dbw = 8'h00;
  logic       we = 1'b0, re = 1'b0, rx = 1'b1;
  logic [7:0] dbr;
  logic       tx;

  uart_buffered #(.CLK_HZ(1612800), .BAUD(115200), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .addr(addr), .dbw(dbw), .we(we), .re(re),
    .dbr(dbr), .rx(rx), .tx(tx));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // ---------------- read scoreboard ----------------
  typedef struct { string nm; logic [7:0] v; } rd_exp_t;
  rd_exp_t rd_q[$];
  logic    rd_vld = 1'b0;

  always @(negedge clk) begin
    if (rd_vld && rd_q.size() > 0) begin
      rd_exp_t e;
      e = rd_q.pop_front();
      chk(e.nm, dbr, e.v);
    end
  end

  task automatic rd(input logic [1:0] a, input logic pop, input logic [7:0] exp, input string nm);
    @(posedge clk); #1;
    addr = a; re = pop; rd_vld = 1'b1;
    rd_q.push_back('{nm, exp});
    @(posedge clk); #1;
    re = 1'b0; rd_vld = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    addr = a; dbw = d; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  // ---------------- TX scoreboard ----------------
  typedef struct { logic [7:0] b; bit b2b; } tx_exp_t;
  tx_exp_t tx_q[$];
  time     t_prev = 0;

  task automatic send_tx(input logic [7:0] b, input bit b2b);
    tx_q.push_back('{b, b2b});
    wr(UART_REG_DATA, b);
  endtask

  initial begin
    time     t0;
    logic [7:0] sh;
    tx_exp_t e;
    forever begin
      @(negedge tx);
      t0 = $time;
      repeat (P / 2) @(negedge clk);
      chk("tx_start", tx, 0);
      for (int i = 0; i < 8; i++) begin
        repeat (P) @(negedge clk);
        sh[i] = tx;
      end
`ifdef UART_PARITY_EN
      repeat (P) @(negedge clk);
      chk("tx_parity", tx, ^sh);
`endif
      repeat (P) @(negedge clk);
      chk("tx_stop", tx, 1);
      if (tx_q.size() == 0) begin
        n_chk++;
        $display("FAIL tx_extra: got frame 0x%0h expected no frame", sh);
      end else begin
        e = tx_q.pop_front();
        chk("tx_byte", sh, e.b);
        if (e.b2b) chk("tx_gap_clks", 32'((t0 - t_prev) / 10), P * NBITS);
      end
      t_prev = t0;
    end
  end

  task automatic wait_tx(input int max_cyc);
    int n = 0;
    while (tx_q.size() != 0 && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    chk("tx_drain", tx_q.size(), 0);
    repeat (P) @(posedge clk);
  endtask

  // ---------------- RX stimulus ----------------
  // frame bits LSB first: start, data, [parity], stop
  function automatic logic [10:0] frm(input logic [7:0] b, input logic stop);
`ifdef UART_PARITY_EN
    return {stop, ^b, b, 1'b0};
`else
    return {1'b1, stop, b, 1'b0};
`endif
  endfunction

  task automatic send_rx(input logic [10:0] f);
    @(posedge clk); #1;
    for (int i = 0; i < NBITS; i++) begin
      rx = f[i];
      repeat (P) @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk("rst_tx", tx, 1);
    rd(UART_REG_DATA,   1'b0, 8'h00, "rst_data");
    rd(UART_REG_STATUS, 1'b0, 8'h00, "rst_status");
    rd(UART_REG_DIV_LO, 1'b0, 8'h0D, "rst_div_lo");
    rd(UART_REG_DIV_HI, 1'b0, 8'h00, "rst_div_hi");

    // divisor read/write, then restore
    wr(UART_REG_DIV_LO, 8'h2A);
    wr(UART_REG_DIV_HI, 8'h01);
    rd(UART_REG_DIV_LO, 1'b0, 8'h2A, "div_lo_wr");
    rd(UART_REG_DIV_HI, 1'b0, 8'h01, "div_hi_wr");
    wr(UART_REG_DIV_LO, 8'h0D);
    wr(UART_REG_DIV_HI, 8'h00);

    // two back-to-back frames; start bit 2 clocks after the write edge
    send_tx(8'h7B, 1'b0);
    @(negedge clk) chk("tx_lat0", tx, 1);
    @(negedge clk) chk("tx_lat1", tx, 1);
    @(negedge clk) chk("tx_lat2", tx, 0);
    send_tx(8'h3E, 1'b1);
    rd(UART_REG_STATUS, 1'b0, 8'h01, "busy_f1");
    repeat (150) @(posedge clk);
    rd(UART_REG_STATUS, 1'b0, 8'h01, "busy_f2");
    wait_tx(400);
    rd(UART_REG_STATUS, 1'b0, 8'h00, "tx_idle");

    // fill TX FIFO behind an in-flight frame; 17th write dropped
    send_tx(8'hC0, 1'b0);
    for (int i = 0; i < 16; i++) send_tx(8'(8'h10 + i), 1'b1);
    rd(UART_REG_STATUS, 1'b0, 8'h81, "tx_full");
    wr(UART_REG_DATA, 8'hEE);
    rd(UART_REG_STATUS, 1'b0, 8'h81, "tx_full_drop");
    wait_tx(17 * P * NBITS + 200);
    rd(UART_REG_STATUS, 1'b0, 8'h00, "tx_all_done");

    // RX two frames
    send_rx(frm(8'hA5, 1'b1));
    send_rx(frm(8'h01, 1'b1));
    rd(UART_REG_STATUS, 1'b0, 8'h40, "rx_ne");
    rd(UART_REG_DATA,   1'b0, 8'hA5, "rx_peek");
    rd(UART_REG_DATA,   1'b1, 8'hA5, "rx_pop0");
    rd(UART_REG_DATA,   1'b1, 8'h01, "rx_pop1");
    rd(UART_REG_DATA,   1'b0, 8'h00, "rx_empty_data");
    rd(UART_REG_STATUS, 1'b0, 8'h00, "rx_empty_status");

    // overrun: 17 frames, no pops
    for (int i = 0; i < 17; i++) send_rx(frm(8'(8'h20 + i), 1'b1));
    rd(UART_REG_STATUS, 1'b1, 8'h60, "ovr_set");
    rd(UART_REG_STATUS, 1'b0, 8'h40, "ovr_clr");
    for (int i = 0; i < 16; i++) rd(UART_REG_DATA, 1'b1, 8'(8'h20 + i), "ovr_byte");
    rd(UART_REG_STATUS, 1'b0, 8'h00, "ovr_drained");

    // framing error, byte still delivered
    send_rx(frm(8'h55, 1'b0));
    rd(UART_REG_STATUS, 1'b1, 8'h50, "frm_set");
    rd(UART_REG_DATA,   1'b1, 8'h55, "frm_byte");
    rd(UART_REG_STATUS, 1'b0, 8'h00, "frm_clr");

    // 1-clock glitch must not produce a byte
    @(posedge clk); #1 rx = 1'b0;
    @(posedge clk); #1 rx = 1'b1;
    repeat (40) @(posedge clk);
    rd(UART_REG_STATUS, 1'b0, 8'h00, "glitch_status");
    rd(UART_REG_DATA,   1'b0, 8'h00, "glitch_data");

`ifdef UART_PARITY_EN
    // 0x03 has even parity bit 0 (checked by the decoder)
    send_tx(8'h03, 1'b0);
    wait_tx(2 * P * NBITS);
    // 0x01 sent with parity bit 0 (should be 1)
    send_rx(11'b1_0_00000001_0);
    rd(UART_REG_STATUS, 1'b1, 8'h48, "par_set");
    rd(UART_REG_DATA,   1'b1, 8'h01, "par_byte");
    rd(UART_REG_STATUS, 1'b0, 8'h00, "par_clr");
`endif

    repeat (20) @(posedge clk);
    chk("tx_q_left", tx_q.size(), 0);
    chk("tx_final", tx, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
